timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable down-counter timer on the CPU's data-side bus. It sits directly downstream of the pipelined core's M stage: it consumes the data address, write data and byte enables, and returns read data. Its interrupt request feeds the CP0 hardware-interrupt input. It provides one-shot (mode 0) and auto-reload (mode 1) operation, with a maskable level interrupt.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: block base address. A bus access hits when addr[31:4] == BASE_ADDR[31:4].
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `addr` input 32: byte address from the M stage. Register select is addr[3:2]; addr[1:0] is ignored.
- `we` input 1: write strobe. It is qualified by the address hit.
- `byteen` input 4: per-byte write enable. Bit i writes wdata[8i+7:8i].
- `wdata` input 32: write data.
- `rdata` output 32: combinational read data.
- `irq` output 1: interrupt request, equal to CTRL.IM & irq_flag.

## Operation
- Register map:
  - 0x0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM. Bits 31:4 are read-only and read 0.
  - 0x4 PRESET: 32-bit read/write.
  - 0x8 COUNT: 32-bit read-only. Writes are ignored.
  - 0xC: reads 0, writes are ignored.
- MODE values: 2'b00 is one-shot, 2'b01 is auto-reload. MODE 2'b1x behaves as one-shot.
- Write rule:
  - A write occurs when `we` is high and the address hits.
  - Only bytes with byteen set are updated, at the next clk edge.
  - Any write to CTRL or PRESET forces state to IDLE and clears irq_flag, even when byteen is 0.
- Read rule: rdata is the selected register on a hit, else 0. It is independent of `we`.
- FSM (2-bit state: IDLE, LOAD, CNT, INT):
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE with COUNT held.
    - Else if COUNT > 1, COUNT <= COUNT - 1.
    - Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - One-shot: EN <= 0 and irq_flag is held.
    - Auto-reload: irq_flag <= 0.
    - In both modes, go to IDLE.
- irq_flag in one-shot mode stays set until the next CTRL/PRESET write. Masking through IM hides `irq` but keeps the flag.
- Simultaneous events:
  - A software write in the same cycle as an FSM update takes priority for every register field it touches, and for state and irq_flag.
  - A CTRL write during INT wins over the hardware EN clear.
- PRESET = 0 or 1: LOAD, then one CNT cycle, then INT. COUNT reaches 0 with no wrap-around. COUNT never decrements below 0.

## Timing
- Reset (asynchronous assert, synchronous release on clk): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0. Consequently irq = 0 and rdata reads 0 for all registers.
- Reset mid-count aborts immediately. No interrupt is produced.
- rdata has 0-cycle latency, combinational from addr and the registers.
- irq is a combinational AND of registered bits. It has no glitch path from bus inputs except IM via a register.
- Enable written at edge e0 with PRESET = N ≥ 1:
  - e1: state enters LOAD.
  - e2: COUNT = N.
  - e(N+1): COUNT = 1.
  - e(N+2): COUNT = 0 and irq rises (if IM).
- One-shot: irq stays high until a CTRL/PRESET write. EN reads 0 from e(N+3).
- Auto-reload: irq is high for exactly one cycle (e(N+2) to e(N+3)). The period between irq pulses is N+3 cycles.
- Clearing EN during CNT: COUNT freezes from the next edge. Re-enabling restarts from LOAD, reloading PRESET.

## Test plan
- Reset: assert reset low mid-count with PRESET = 5 → all reads return 0 and irq = 0 immediately. After release, the block stays in IDLE with COUNT = 0.
- One-shot: write PRESET = 5, then CTRL = 0x9 (EN, IM, mode 0) at e0 → COUNT reads 5, 4, 3, 2, 1 on e2–e6. irq rises after e7 and holds for 20 cycles. CTRL reads 0x8. A write of CTRL = 0x8 drops irq next cycle.
- Auto-reload: PRESET = 3, CTRL = 0xB → irq pulses exactly one cycle wide, every 6 cycles, for 4 periods.
- Mask and byte enables:
  - Mode 0 with IM = 0 → flag sets, irq stays 0.
  - Write byteen = 4'b0001 with wdata = 0xFFFF_FF09 → CTRL reads 0x9.
  - PRESET written with byteen = 4'b1100, wdata = 0xABCD_0000 over 0x1234 → PRESET reads 0xABCD_1234.
- Boundaries:
  - PRESET = 0 → irq 3 edges after the enable write.
  - A write to COUNT (0x8) and to 0xC → no change; both read as before (0xC reads 0).
  - An access with addr outside BASE_ADDR → no write, rdata = 0.
- Collision: with mode 0 and PRESET = 2, write CTRL = 0x9 in the exact INT cycle → EN stays 1, irq_flag clears, and the counter restarts. irq reasserts 4 edges later.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter timer with one-shot and auto-reload
// modes and a maskable level interrupt. Register map (word offsets from base):
//   0x0 CTRL {IM, MODE[1:0], EN}, 0x4 PRESET, 0x8 COUNT (RO), 0xC reads 0.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StCnt  = 2'd2;
  localparam logic [1:0] StInt  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic [1:0]  sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        auto_reload;
  logic        en_hw_clr;
  logic        unused_addr;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = addr[3:2];
  assign wr_ctrl     = we && hit && (sel == 2'd0);
  assign wr_preset   = we && hit && (sel == 2'd1);
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign unused_addr = ^addr[1:0];

  // Counter FSM next-state; a CTRL/PRESET write overrides state and flag.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    en_hw_clr  = 1'b0;
    case (state_q)
      StIdle: begin
        if (ctrl_q[0]) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_q[0]) begin
          state_d = StIdle;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 or 1 lands here straight away; never wrap below 0.
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        if (auto_reload) irq_flag_d = 1'b0;
        else             en_hw_clr  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (wr_ctrl || wr_preset) begin
      state_d    = StIdle;
      irq_flag_d = 1'b0;
    end
  end

  // Software-visible register updates; a CTRL byte-0 write beats the EN clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (en_hw_clr) ctrl_d[0] = 1'b0;
    if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
    for (int i = 0; i < 4; i++) begin
      if (wr_preset && byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Combinational read mux, independent of the write strobe.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (sel)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes expected rdata/irq from a
// timeline reference model; a negedge monitor pops and compares.
module tb_timer_counter;

  localparam logic [31:0] B = 32'h0000_7F00;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  timer_counter #(.BASE_ADDR(B)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_rd[$];
  logic        q_irq[$];
  string       q_name[$];

  // Reference model: registers plus a timeline. A run starts at the edge where
  // IDLE sees EN; k = edges since the idle edge before it. k==2 loads COUNT,
  // then one decrement per edge down to 1, then COUNT=0 with the flag, then the
  // end-of-interrupt edge.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  bit          m_run;
  longint      m_t0;
  longint      edge_n;

  function automatic void model_clear();
    m_ctrl   = 4'd0;
    m_preset = 32'd0;
    m_count  = 32'd0;
    m_flag   = 1'b0;
    m_run    = 1'b0;
    m_t0     = 0;
  endfunction

  // Called right after each posedge, with the bus inputs the DUT just sampled.
  function automatic void model_edge();
    longint k;
    longint np;
    bit     en;
    bit     auto_mode;
    if (!reset) begin
      model_clear();
      edge_n++;
      return;
    end
    en        = m_ctrl[0];
    auto_mode = (m_ctrl[2:1] == 2'b01);
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_t0  = edge_n - 1;
      end
    end else begin
      k  = edge_n - m_t0;
      np = (m_preset <= 32'd1) ? 1 : longint'(m_preset);
      if (k == 2) begin
        m_count = m_preset;
      end else if (k <= np + 2) begin
        if (!en) m_run = 1'b0;
        else if (k <= np + 1) m_count = m_preset - 32'(k - 2);
        else begin
          m_count = 32'd0;
          m_flag  = 1'b1;
        end
      end else begin
        if (auto_mode) m_flag = 1'b0;
        else           m_ctrl[0] = 1'b0;
        m_run = 1'b0;
      end
    end
    if (we && addr[31:4] == B[31:4]) begin
      if (addr[3:2] == 2'd0) begin
        if (byteen[0]) m_ctrl = wdata[3:0];
        m_run  = 1'b0;
        m_flag = 1'b0;
      end else if (addr[3:2] == 2'd1) begin
        for (int i = 0; i < 4; i++) if (byteen[i]) m_preset[8*i +: 8] = wdata[8*i +: 8];
        m_run  = 1'b0;
        m_flag = 1'b0;
      end
    end
    edge_n++;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a[31:4] != B[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return m_ctrl[3] & m_flag;
  endfunction

  task automatic drive(input logic [31:0] a, input logic w, input logic [3:0] be,
                       input logic [31:0] d);
    addr   = a;
    we     = w;
    byteen = be;
    wdata  = d;
  endtask

  // One bus cycle, expectation taken from the model.
  task automatic cycle(input logic [31:0] a, input logic w, input logic [3:0] be,
                       input logic [31:0] d);
    @(posedge clk);
    model_edge();
    #1;
    drive(a, w, be, d);
    q_rd.push_back(exp_rd(a));
    q_irq.push_back(exp_irq());
    q_name.push_back("model");
  endtask

  // One read cycle with a fixed expected rdata.
  task automatic cycle_exp(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(posedge clk);
    model_edge();
    #1;
    drive(a, 1'b0, 4'h0, 32'd0);
    q_rd.push_back(exp);
    q_irq.push_back(exp_irq());
    q_name.push_back(name);
  endtask

  task automatic set_reset(input logic r, input logic [31:0] a);
    @(posedge clk);
    model_edge();
    #1;
    reset = r;
    if (!r) model_clear();
    drive(a, 1'b0, 4'h0, 32'd0);
    q_rd.push_back(exp_rd(a));
    q_irq.push_back(exp_irq());
    q_name.push_back(r ? "rst_release" : "rst_assert");
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cycle(a, 1'b1, be, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle(a, 1'b0, 4'h0, 32'd0);
  endtask

  // Monitor: compares whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (q_rd.size() > 0) begin
      logic [31:0] erd;
      logic        eirq;
      string       nm;
      erd  = q_rd.pop_front();
      eirq = q_irq.pop_front();
      nm   = q_name.pop_front();
      checks++;
      if (rdata !== erd) begin
        errors++;
        $display("FAIL %s rdata addr=%h got %h exp %h t=%0t", nm, addr, rdata, erd, $time);
      end
      checks++;
      if (irq !== eirq) begin
        errors++;
        $display("FAIL %s irq got %b exp %b t=%0t", nm, irq, eirq, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b0;
    edge_n = 0;
    model_clear();
    drive(B, 1'b0, 4'h0, 32'd0);
    repeat (2) cycle_exp(B + 32'h0, 32'd0, "rst_ctrl");
    set_reset(1'b1, B + 32'h8);
    repeat (3) cycle_exp(B + 32'h8, 32'd0, "rst_count");

    // One-shot, PRESET=5, IM=1.
    wr(B + 32'h4, 4'hF, 32'd5);
    wr(B + 32'h0, 4'hF, 32'h9);
    cycle_exp(B + 32'h8, 32'd0, "os_e0");
    cycle_exp(B + 32'h8, 32'd0, "os_e1");
    for (int i = 5; i >= 0; i--) cycle_exp(B + 32'h8, 32'(i), "os_count");
    repeat (20) rd(B + 32'h8);
    cycle_exp(B + 32'h0, 32'h8, "os_ctrl_en_clr");
    wr(B + 32'h0, 4'hF, 32'h8);
    repeat (3) rd(B + 32'h0);

    // Auto-reload, PRESET=3: one-cycle pulses every 6 cycles.
    wr(B + 32'h4, 4'hF, 32'd3);
    wr(B + 32'h0, 4'hF, 32'hB);
    repeat (28) rd(B + 32'h8);
    wr(B + 32'h0, 4'hF, 32'h0);

    // Masked one-shot: flag sets, irq stays low.
    wr(B + 32'h4, 4'hF, 32'd2);
    wr(B + 32'h0, 4'hF, 32'h1);
    repeat (8) rd(B + 32'h8);
    cycle_exp(B + 32'h0, 32'h0, "mask_en_clr");

    // Byte enables.
    wr(B + 32'h0, 4'b0001, 32'hFFFF_FF09);
    cycle_exp(B + 32'h0, 32'h9, "be_ctrl");
    wr(B + 32'h0, 4'hF, 32'h0);
    wr(B + 32'h4, 4'hF, 32'h0000_1234);
    wr(B + 32'h4, 4'b1100, 32'hABCD_0000);
    cycle_exp(B + 32'h4, 32'hABCD_1234, "be_preset");

    // PRESET=0: irq three edges after the enable write.
    wr(B + 32'h4, 4'hF, 32'd0);
    wr(B + 32'h0, 4'hF, 32'h9);
    repeat (6) rd(B + 32'h8);
    wr(B + 32'h0, 4'hF, 32'h0);

    // Freeze by clearing EN mid-count, then writes to COUNT / 0xC / off-base.
    wr(B + 32'h4, 4'hF, 32'd7);
    wr(B + 32'h0, 4'hF, 32'h1);
    repeat (4) rd(B + 32'h8);
    wr(B + 32'h0, 4'hF, 32'h0);
    repeat (3) rd(B + 32'h8);
    wr(B + 32'h8, 4'hF, 32'hDEAD_BEEF);
    wr(B + 32'hC, 4'hF, 32'hDEAD_BEEF);
    rd(B + 32'h8);
    cycle_exp(B + 32'hC, 32'd0, "reg_c");
    wr(32'h0000_7E04, 4'hF, 32'h55);
    cycle_exp(32'h0000_7E04, 32'd0, "miss_rd");
    cycle_exp(B + 32'h4, 32'd7, "miss_nowrite");
    wr(B + 32'h0, 4'hF, 32'h1);
    repeat (3) rd(B + 32'h8);

    // Collision: CTRL write during INT wins over the EN clear.
    wr(B + 32'h0, 4'hF, 32'h0);
    wr(B + 32'h4, 4'hF, 32'd2);
    wr(B + 32'h0, 4'hF, 32'h9);
    repeat (4) rd(B + 32'h8);
    wr(B + 32'h0, 4'hF, 32'h9);
    cycle_exp(B + 32'h0, 32'h9, "coll_en");
    repeat (8) rd(B + 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      op = $urandom_range(0, 99);
      if (op < 40) rd(B + 32'($urandom_range(0, 15)));
      else if (op < 65) wr(B + 32'h0, 4'($urandom), 32'($urandom));
      else if (op < 85) wr(B + 32'h4, 4'($urandom), 32'($urandom_range(0, 6)));
      else if (op < 93) wr(B + 32'($urandom_range(8, 15)), 4'hF, 32'($urandom));
      else cycle(32'($urandom), 1'($urandom), 4'($urandom), 32'($urandom));
    end

    // Reset mid-count aborts at once.
    wr(B + 32'h4, 4'hF, 32'd5);
    wr(B + 32'h0, 4'hF, 32'h9);
    repeat (3) rd(B + 32'h8);
    set_reset(1'b0, B + 32'h8);
    cycle_exp(B + 32'h0, 32'd0, "rst_mid_ctrl");
    cycle_exp(B + 32'h4, 32'd0, "rst_mid_preset");
    set_reset(1'b1, B + 32'h8);
    repeat (5) cycle_exp(B + 32'h8, 32'd0, "rst_idle_count");
    cycle_exp(B + 32'h0, 32'd0, "rst_idle_ctrl");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q_rd.size() != 0) begin
      errors++;
      $display("FAIL drain queue size got %0d exp 0", q_rd.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
